// File: rtl/axi4_slave_ram_pkg.sv
// Shared AXI4 encodings, FSM state types and per-beat response helpers for the
// axi4_slave_ram responder.
package axi4_slave_ram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Decode error outranks a malformed request; only clean beats touch the RAM.
    function automatic logic [1:0] beat_resp(input logic       in_range,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
        if (!in_range)
            return AXI_RESP_DECERR;
        if (size != AXI_SIZE_4B || !(burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR))
            return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

    // The three encodings used here are numerically ordered by severity.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_slave_ram_sdp_ram_be.sv
// Simple dual-port word RAM: one byte-enabled write port, one registered
// read port with read enable and read-first behaviour on address collision.
module sdp_ram_be #(
    parameter int    MEM_WORDS = 4096,
    parameter int    ADDR_BITS = 12,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [3:0]           wbe,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem [MEM_WORDS];

    // NOTE: the array has no reset branch on purpose -- resetting a memory forces it
    // into flops; contents are only defined by writes.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i])
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 responder backed by an on-chip word RAM with independent read and write
// burst engines (INCR/FIXED, up to 256 beats, byte-strobed writes).
module axi4_slave_ram
    import axi4_slave_ram_pkg::*;
#(
    parameter int    MEM_WORDS  = 4096,
    parameter int    ADDR_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    function automatic logic in_range(input logic [ADDR_WIDTH-3:0] word);
        return {1'b0, word} < (ADDR_WIDTH-1)'(MEM_WORDS);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0]            burst);
        return (burst == AXI_BURST_FIXED) ? a : a + ADDR_WIDTH'(4);
    endfunction

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst, r_resp, r_issue_resp;
    logic                  r_last, ar_hs, r_advance;
    logic                  ram_re;
    logic [RAM_AW-1:0]     ram_raddr;
    logic [31:0]           ram_rdata;

    assign ar_hs      = (r_state == R_IDLE) && S_AXI_ARVALID;
    assign r_advance  = (r_state == R_DATA) && S_AXI_RREADY && !r_last;
    assign r_addr_nxt = next_addr(r_addr, r_burst);
    assign r_issue_resp = ar_hs
        ? beat_resp(in_range(S_AXI_ARADDR[ADDR_WIDTH-1:2]), S_AXI_ARSIZE, S_AXI_ARBURST)
        : beat_resp(in_range(r_addr_nxt[ADDR_WIDTH-1:2]), r_size, r_burst);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    // NOTE: defaulting every combinational output first keeps all paths assigned
    // and prevents latch inference.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (S_AXI_ARVALID) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // The RAM read is launched on the AR handshake or on an accepted beat, so a
    // held RREADY streams one beat per cycle; a stall keeps the RAM output frozen.
    always_comb begin
        S_AXI_ARREADY = (r_state == R_IDLE);
        S_AXI_RVALID  = (r_state == R_DATA);
        S_AXI_RLAST   = S_AXI_RVALID && r_last;
        S_AXI_RRESP   = S_AXI_RVALID ? r_resp : AXI_RESP_OKAY;
        S_AXI_RDATA   = (S_AXI_RVALID && r_resp == AXI_RESP_OKAY) ? ram_rdata : 32'h0;
        ram_re        = (ar_hs || r_advance) && (r_issue_resp == AXI_RESP_OKAY);
        ram_raddr     = ar_hs ? S_AXI_ARADDR[RAM_AW+1:2] : r_addr_nxt[RAM_AW+1:2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_resp  <= AXI_RESP_OKAY;
            r_last  <= 1'b0;
        end else if (ar_hs) begin
            r_addr  <= S_AXI_ARADDR;
            r_len   <= S_AXI_ARLEN;
            r_cnt   <= '0;
            r_size  <= S_AXI_ARSIZE;
            r_burst <= S_AXI_ARBURST;
            r_resp  <= r_issue_resp;
            r_last  <= (S_AXI_ARLEN == 8'd0);
        end else if (r_advance) begin
            r_addr  <= r_addr_nxt;
            r_cnt   <= r_cnt + 8'd1;
            r_resp  <= r_issue_resp;
            r_last  <= (r_cnt + 8'd1 == r_len);
        end
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_bresp, w_addr_resp, w_beat_resp;
    logic                  aw_hs, w_beat, w_is_last, ram_we;

    assign aw_hs       = (w_state == W_IDLE) && S_AXI_AWVALID;
    assign w_beat      = (w_state == W_DATA) && S_AXI_WVALID;
    assign w_is_last   = (w_cnt == w_len);
    assign w_addr_resp = beat_resp(in_range(w_addr[ADDR_WIDTH-1:2]), w_size, w_burst);
    // A WLAST that disagrees with the beat count flags the burst but never shortens it.
    assign w_beat_resp = worst_resp(w_addr_resp,
                                    (S_AXI_WLAST != w_is_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    assign ram_we      = w_beat && (w_beat_resp == AXI_RESP_OKAY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            w_state <= W_IDLE;
        else
            w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (S_AXI_AWVALID) w_next = W_DATA;
            W_DATA:  if (S_AXI_WVALID && w_is_last) w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = (w_state == W_IDLE);
        S_AXI_WREADY  = (w_state == W_DATA);
        S_AXI_BVALID  = (w_state == W_RESP);
        S_AXI_BRESP   = S_AXI_BVALID ? w_bresp : AXI_RESP_OKAY;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bresp <= AXI_RESP_OKAY;
        end else if (aw_hs) begin
            w_addr  <= S_AXI_AWADDR;
            w_len   <= S_AXI_AWLEN;
            w_cnt   <= '0;
            w_size  <= S_AXI_AWSIZE;
            w_burst <= S_AXI_AWBURST;
            w_bresp <= AXI_RESP_OKAY;
        end else if (w_beat) begin
            w_addr  <= next_addr(w_addr, w_burst);
            w_cnt   <= w_cnt + 8'd1;
            w_bresp <= worst_resp(w_bresp, w_beat_resp);
        end
    end

    sdp_ram_be #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_BITS (RAM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wbe   (S_AXI_WSTRB),
        .waddr (w_addr[RAM_AW+1:2]),
        .wdata (S_AXI_WDATA),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Scoreboard bench for axi4_slave_ram: stimulus queues expected R beats and B
// responses, a negedge monitor pops and compares whenever a handshake occurs.
module tb_axi4_slave_ram;
    import axi4_slave_ram_pkg::*;

    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    axi4_slave_ram #(.MEM_WORDS(4096), .ADDR_WIDTH(32), .INIT_FILE("")) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_beat_t;

    r_beat_t    r_exp[$];
    logic [1:0] b_exp[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
        r_beat_t b;
        b.data = data;
        b.resp = resp;
        b.last = last;
        r_exp.push_back(b);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARSIZE = size; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) break;
        end
        if (!S_AXI_ARREADY) check("ar_ready_timeout", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = size; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY) break;
        end
        if (!S_AXI_AWREADY) check("aw_ready_timeout", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = last;
        S_AXI_WVALID = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (S_AXI_WREADY) break;
        end
        if (!S_AXI_WREADY) check("w_ready_timeout", 32'(S_AXI_WREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (r_exp.size() == 0 && b_exp.size() == 0 && !S_AXI_RVALID && !S_AXI_BVALID) break;
        end
        if (r_exp.size() != 0) check("r_drain_timeout", 32'(r_exp.size()), 32'd0);
        if (b_exp.size() != 0) check("b_drain_timeout", 32'(b_exp.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic write_single(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] resp);
        b_exp.push_back(resp);
        aw_send(addr, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        w_send(data, strb, 1'b1);
        wait_drain();
    endtask

    // Monitor: compares every accepted R beat / B response against the queues,
    // and checks that a stalled R beat already shows the value it will deliver.
    always @(negedge clk) begin
        r_beat_t e;
        logic [1:0] be;
        if (resetn) begin
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (r_exp.size() == 0) begin
                    check("r_extra_beat", 32'(r_exp.size()), 32'd1);
                end else begin
                    e = r_exp.pop_front();
                    check("r_data", S_AXI_RDATA, e.data);
                    check("r_resp", 32'(S_AXI_RRESP), 32'(e.resp));
                    check("r_last", 32'(S_AXI_RLAST), 32'(e.last));
                end
            end else if (S_AXI_RVALID && r_exp.size() != 0) begin
                check("r_stall_data", S_AXI_RDATA, r_exp[0].data);
                check("r_stall_last", 32'(S_AXI_RLAST), 32'(r_exp[0].last));
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (b_exp.size() == 0) begin
                    check("b_extra_resp", 32'(b_exp.size()), 32'd1);
                end else begin
                    be = b_exp.pop_front();
                    check("b_resp", 32'(S_AXI_BRESP), 32'(be));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = AXI_SIZE_4B; S_AXI_AWBURST = AXI_BURST_INCR;
        S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = AXI_SIZE_4B; S_AXI_ARBURST = AXI_BURST_INCR;
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0;
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rlast",   32'(S_AXI_RLAST),   32'd0);
        check("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
        check("rst_rdata",   S_AXI_RDATA,        32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single write then single read with latency check.
        write_single(32'h100, 32'hDEADBEEF, 4'hF, AXI_RESP_OKAY);
        push_r(32'hDEADBEEF, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h100, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        @(negedge clk); check("r_latency_fetch", 32'(S_AXI_RVALID), 32'd0);
        @(negedge clk); check("r_latency_valid", 32'(S_AXI_RVALID), 32'd1);
        wait_drain();

        // Eight-beat INCR write of words 0..7, then back-to-back read.
        b_exp.push_back(AXI_RESP_OKAY);
        aw_send(32'h0, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR);
        for (int i = 0; i < 8; i++) w_send(32'hC0DE_0000 + 32'(i), 4'hF, i == 7);
        wait_drain();
        for (int i = 0; i < 8; i++) push_r(32'hC0DE_0000 + 32'(i), AXI_RESP_OKAY, i == 7);
        ar_send(32'h0, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("burst_rvalid_run", 32'(S_AXI_RVALID), 32'd1);
        end
        @(negedge clk); check("burst_rvalid_end", 32'(S_AXI_RVALID), 32'd0);
        wait_drain();

        // Same burst with RREADY toggling.
        for (int i = 0; i < 8; i++) push_r(32'hC0DE_0000 + 32'(i), AXI_RESP_OKAY, i == 7);
        ar_send(32'h0, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR);
        for (int i = 0; i < 20; i++) begin
            S_AXI_RREADY = i[0];
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b1;
        wait_drain();

        // FIXED burst repeats the same word.
        for (int i = 0; i < 3; i++) push_r(32'hC0DE_0002, AXI_RESP_OKAY, i == 2);
        ar_send(32'h8, 8'd2, AXI_SIZE_4B, AXI_BURST_FIXED);
        wait_drain();

        // Byte strobes.
        write_single(32'h40, 32'h11223344, 4'hF, AXI_RESP_OKAY);
        write_single(32'h40, 32'hAABBCCDD, 4'b0101, AXI_RESP_OKAY);
        push_r(32'h11BB33DD, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h40, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        // Burst running off the top of memory.
        write_single(32'h3FFC, 32'hFEEDF00D, 4'hF, AXI_RESP_OKAY);
        push_r(32'hFEEDF00D, AXI_RESP_OKAY, 1'b0);
        push_r(32'h0, AXI_RESP_DECERR, 1'b1);
        ar_send(32'h3FFC, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        // Read errors: decode, bad size, and decode outranking bad size.
        push_r(32'h0, AXI_RESP_DECERR, 1'b0);
        push_r(32'h0, AXI_RESP_DECERR, 1'b1);
        ar_send(32'h4000, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();
        push_r(32'h0, AXI_RESP_SLVERR, 1'b1);
        ar_send(32'h100, 8'd0, 3'b001, AXI_BURST_INCR);
        wait_drain();
        push_r(32'h0, AXI_RESP_DECERR, 1'b1);
        ar_send(32'h4000, 8'd0, 3'b001, AXI_BURST_INCR);
        wait_drain();

        // Write errors: WLAST early on beat 1 of 4, and a reserved burst type
        // that must leave the RAM untouched.
        b_exp.push_back(AXI_RESP_SLVERR);
        aw_send(32'h200, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR);
        for (int i = 0; i < 4; i++) w_send(32'h5A5A_0000 + 32'(i), 4'hF, i == 1);
        wait_drain();
        write_single(32'h300, 32'h12345678, 4'hF, AXI_RESP_OKAY);
        b_exp.push_back(AXI_RESP_SLVERR);
        aw_send(32'h300, 8'd0, AXI_SIZE_4B, 2'b10);
        w_send(32'h0BADF00D, 4'hF, 1'b1);
        wait_drain();
        push_r(32'h12345678, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h300, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        // Held-off B: response and AWREADY must stay put while BREADY is low.
        S_AXI_BREADY = 1'b0;
        b_exp.push_back(AXI_RESP_DECERR);
        aw_send(32'h4000, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        w_send(32'h77777777, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_bvalid",  32'(S_AXI_BVALID),  32'd1);
            check("bhold_bresp",   32'(S_AXI_BRESP),   32'(AXI_RESP_DECERR));
            check("bhold_awready", 32'(S_AXI_AWREADY), 32'd0);
        end
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b1;
        wait_drain();

        // AW and AR in the same cycle: the read sees the old word.
        write_single(32'h80, 32'h1, 4'hF, AXI_RESP_OKAY);
        push_r(32'h1, AXI_RESP_OKAY, 1'b1);
        b_exp.push_back(AXI_RESP_OKAY);
        fork
            aw_send(32'h80, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
            ar_send(32'h80, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        join
        w_send(32'h2, 4'hF, 1'b1);
        wait_drain();
        push_r(32'h2, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h80, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        // RAM write and read of the same word on the same edge: read-first.
        write_single(32'h84, 32'h5, 4'hF, AXI_RESP_OKAY);
        push_r(32'h5, AXI_RESP_OKAY, 1'b1);
        b_exp.push_back(AXI_RESP_OKAY);
        fork
            begin
                aw_send(32'h84, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
                w_send(32'h6, 4'hF, 1'b1);
            end
            begin
                @(posedge clk); #1;
                ar_send(32'h84, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
            end
        join
        wait_drain();
        push_r(32'h6, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h84, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        // Reset during beat 3 of an eight-beat read.
        for (int i = 0; i < 3; i++) push_r(32'hC0DE_0000 + 32'(i), AXI_RESP_OKAY, 1'b0);
        ar_send(32'h0, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_rvalid_before", 32'(S_AXI_RVALID), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("midrst_rlast",  32'(S_AXI_RLAST),  32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("midrst_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        push_r(32'hDEADBEEF, AXI_RESP_OKAY, 1'b1);
        ar_send(32'h100, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR);
        wait_drain();

        check("final_r_queue", 32'(r_exp.size()), 32'd0);
        check("final_b_queue", 32'(b_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
